// File: rtl/otter_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : otter_arb_pkg
// Brief    : Shared types and encodings for the OTTER memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package otter_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int MEM_SIZE_W = 2;

  localparam logic [MEM_SIZE_W-1:0] SIZE_B = 2'd0;
  localparam logic [MEM_SIZE_W-1:0] SIZE_H = 2'd1;
  localparam logic [MEM_SIZE_W-1:0] SIZE_W = 2'd2;

endpackage
`default_nettype wire

// File: rtl/otter_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : otter_mem_arbiter_if
// Brief    : IF/DM requester buses plus the shared memory command/response port.
// Revision : 1.0 - initial release
// ============================================================================
interface otter_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import otter_arb_pkg::*;

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [MEM_SIZE_W-1:0] dm_size;
  logic                  dm_sign;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [MEM_SIZE_W-1:0] mem_size;
  logic                  mem_sign;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  stall_if;
  logic                  stall_dm;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_size, dm_sign,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_size, mem_sign,
    output stall_if, stall_dm
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_size, dm_sign,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_size, mem_sign,
    input  stall_if, stall_dm
  );

endinterface
`default_nettype wire

// File: rtl/otter_mem_arbiter_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module   : otter_arb_perf_cnt
// Brief    : 32-bit wrapping enable counter; used only with OTTER_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module otter_arb_perf_cnt (
  input  wire logic        CLK,
  input  wire logic        RST,
  input  wire logic        i_en,
  output logic [31:0]      o_cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST)       r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 32'd1;
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/otter_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : otter_mem_arbiter
// Brief    : Shares one memory port between IF and DM with read-latency
//            tracking; OTTER_ARB_PERF_EN adds stall-cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_LAT       = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  wire logic           CLK,
  input  wire logic           RST,
  otter_mem_arbiter_if.slave  bus
`ifdef OTTER_ARB_PERF_EN
  ,
  output logic [31:0]         perf_if_stall,
  output logic [31:0]         perf_dm_stall
`endif
);

  localparam logic [1:0]        c_LAT_LAST  = 2'(MEM_LAT - 1);
  localparam int                c_STREAK_W  = $clog2(MAX_DM_STREAK + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_DM_STREAK);
  localparam logic [ADDR_W-1:0] c_ADDR_ZERO = '0;
  localparam logic [DATA_W-1:0] c_DATA_ZERO = '0;

  arb_state_t            r_state, w_state_nxt;
  owner_t                r_owner, w_owner_nxt;
  logic [1:0]            r_lat_cnt, w_lat_nxt;
  logic [c_STREAK_W-1:0] r_streak, w_streak_nxt;

  logic w_rd_done, w_open, w_if_forced, w_gnt_if, w_gnt_dm, w_rv;
  logic w_stall_if, w_stall_dm;

  // Grants and rvalid are masked during RST so every output reads 0 then.
  assign w_rd_done   = (r_state == ARB_WAIT) && (r_lat_cnt == c_LAT_LAST);
  assign w_open      = !RST && ((r_state == ARB_IDLE) || w_rd_done);
  assign w_if_forced = bus.if_req && (r_streak == c_STREAK_MAX);
  assign w_gnt_dm    = w_open && bus.dm_req && !w_if_forced;
  assign w_gnt_if    = w_open && bus.if_req && !w_gnt_dm;
  assign w_rv        = !RST && w_rd_done;
  assign w_stall_if  = !RST && bus.if_req && !w_gnt_if;
  assign w_stall_dm  = !RST && bus.dm_req && !w_gnt_dm;

  assign bus.if_gnt    = w_gnt_if;
  assign bus.dm_gnt    = w_gnt_dm;
  assign bus.stall_if  = w_stall_if;
  assign bus.stall_dm  = w_stall_dm;
  assign bus.if_rvalid = w_rv && (r_owner == OWN_IF);
  assign bus.dm_rvalid = w_rv && (r_owner == OWN_DM);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : c_DATA_ZERO;
  assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : c_DATA_ZERO;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = c_ADDR_ZERO;
    bus.mem_wdata = c_DATA_ZERO;
    bus.mem_size  = '0;
    bus.mem_sign  = 1'b0;
    if (w_gnt_dm) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dm_we;
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_wdata;
      bus.mem_size  = bus.dm_size;
      bus.mem_sign  = bus.dm_sign;
    end else if (w_gnt_if) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.if_addr;
      bus.mem_size  = SIZE_W;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWN_IF;
      r_lat_cnt <= '0;
      r_streak  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_streak  <= w_streak_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_lat_nxt    = r_lat_cnt;
    w_streak_nxt = r_streak;
    if (r_state == ARB_WAIT) begin
      w_lat_nxt = r_lat_cnt + 2'd1;
      if (w_rd_done) w_state_nxt = ARB_IDLE;
    end
    // A read granted in the rvalid cycle chains straight into the next wait.
    if (w_gnt_if || (w_gnt_dm && !bus.dm_we)) begin
      w_state_nxt = ARB_WAIT;
      w_lat_nxt   = '0;
      w_owner_nxt = w_gnt_if ? OWN_IF : OWN_DM;
    end
    if (!bus.if_req || w_gnt_if)
      w_streak_nxt = '0;
    else if (w_gnt_dm && (r_streak != c_STREAK_MAX))
      w_streak_nxt = r_streak + c_STREAK_W'(1);
  end

  a_if_req_held: assert property (@(posedge CLK) disable iff (RST)
    (bus.if_req && !bus.if_gnt) |=> bus.if_req);
  a_dm_req_held: assert property (@(posedge CLK) disable iff (RST)
    (bus.dm_req && !bus.dm_gnt) |=> bus.dm_req);

`ifdef OTTER_ARB_PERF_EN
  otter_arb_perf_cnt u_perf_if (
    .CLK   (CLK),
    .RST   (RST),
    .i_en  (w_stall_if),
    .o_cnt (perf_if_stall)
  );

  otter_arb_perf_cnt u_perf_dm (
    .CLK   (CLK),
    .RST   (RST),
    .i_en  (w_stall_dm),
    .o_cnt (perf_dm_stall)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_otter_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_mem_arbiter
// Brief    : Self-checking bench: MEM_LAT=1 and MEM_LAT=3 arbiters with a
//            read-data scoreboard plus directed grant/stall checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_mem_arbiter;

  logic CLK = 1'b0;
  logic RST;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q1i[$], q1d[$], q3i[$], q3d[$];
  exp_t e1, e3;

  otter_mem_arbiter_if b1 ();
  otter_mem_arbiter_if b3 ();

  logic [31:0] m1;
  logic [31:0] m3 [3];

`ifdef OTTER_ARB_PERF_EN
  logic [31:0] perf1_if, perf1_dm, perf3_if, perf3_dm;
`endif

  otter_mem_arbiter #(.MEM_LAT(1), .MAX_DM_STREAK(4)) u_dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (b1)
`ifdef OTTER_ARB_PERF_EN
    ,
    .perf_if_stall (perf1_if),
    .perf_dm_stall (perf1_dm)
`endif
  );

  otter_mem_arbiter #(.MEM_LAT(3), .MAX_DM_STREAK(4)) u_dut3 (
    .CLK (CLK),
    .RST (RST),
    .bus (b3)
`ifdef OTTER_ARB_PERF_EN
    ,
    .perf_if_stall (perf3_if),
    .perf_dm_stall (perf3_dm)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // Memory models: read data appears MEM_LAT cycles after the command.
  always @(posedge CLK) begin
    m1    <= (b1.mem_en && !b1.mem_we) ? mdata(b1.mem_addr) : 32'hBADB_AD00;
    m3[0] <= (b3.mem_en && !b3.mem_we) ? mdata(b3.mem_addr) : 32'hBADB_AD00;
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign b1.mem_rdata = m1;
  assign b3.mem_rdata = m3[2];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [5:0] fl1();
    return {b1.if_gnt, b1.dm_gnt, b1.stall_if, b1.stall_dm, b1.mem_en, b1.mem_we};
  endfunction
  function automatic logic [5:0] fl3();
    return {b3.if_gnt, b3.dm_gnt, b3.stall_if, b3.stall_dm, b3.mem_en, b3.mem_we};
  endfunction

  // Scoreboards: push on read grant, pop on rvalid; reset drops outstanding reads.
  always @(negedge CLK) begin
    if (RST) begin
      if (b1.if_rvalid || b1.dm_rvalid) check("sb1_rv_in_rst", 1, 0);
      if (b3.if_rvalid || b3.dm_rvalid) check("sb3_rv_in_rst", 1, 0);
      q1i.delete(); q1d.delete(); q3i.delete(); q3d.delete();
    end else begin
      if (b1.if_rvalid) begin
        if (q1i.size() == 0) check("sb1_if_unexp", 1, 0);
        else begin
          e1 = q1i.pop_front();
          check("sb1_if_data", b1.if_rdata, e1.data);
          check("sb1_if_cyc", cyc, e1.cyc);
        end
      end
      if (b1.dm_rvalid) begin
        if (q1d.size() == 0) check("sb1_dm_unexp", 1, 0);
        else begin
          e1 = q1d.pop_front();
          check("sb1_dm_data", b1.dm_rdata, e1.data);
          check("sb1_dm_cyc", cyc, e1.cyc);
        end
      end
      if (b3.if_rvalid) begin
        if (q3i.size() == 0) check("sb3_if_unexp", 1, 0);
        else begin
          e3 = q3i.pop_front();
          check("sb3_if_data", b3.if_rdata, e3.data);
          check("sb3_if_cyc", cyc, e3.cyc);
        end
      end
      if (b3.dm_rvalid) begin
        if (q3d.size() == 0) check("sb3_dm_unexp", 1, 0);
        else begin
          e3 = q3d.pop_front();
          check("sb3_dm_data", b3.dm_rdata, e3.data);
          check("sb3_dm_cyc", cyc, e3.cyc);
        end
      end
      if (b1.if_gnt) q1i.push_back('{mdata(b1.if_addr), cyc + 1});
      if (b1.dm_gnt && !b1.dm_we) q1d.push_back('{mdata(b1.dm_addr), cyc + 1});
      if (b3.if_gnt) q3i.push_back('{mdata(b3.if_addr), cyc + 3});
      if (b3.dm_gnt && !b3.dm_we) q3d.push_back('{mdata(b3.dm_addr), cyc + 3});
    end
  end

  initial begin
    b1.if_req = 1'b1; b1.if_addr = 32'h40; b1.dm_req = 1'b1; b1.dm_we = 1'b0;
    b1.dm_addr = 32'h80; b1.dm_wdata = '0; b1.dm_size = 2'd2; b1.dm_sign = 1'b0;
    b3.if_req = 1'b1; b3.if_addr = 32'h44; b3.dm_req = 1'b1; b3.dm_we = 1'b0;
    b3.dm_addr = 32'h84; b3.dm_wdata = '0; b3.dm_size = 2'd2; b3.dm_sign = 1'b0;
    RST = 1'b1;

    // Reset with both requesters active: every output held at zero.
    @(negedge CLK);
    check("t1_rst_ctl1", {fl1(), b1.if_rvalid, b1.dm_rvalid}, 0);
    check("t1_rst_bus1", {b1.mem_addr, b1.mem_size, b1.mem_sign, b1.if_rdata}, 0);
    check("t1_rst_ctl3", {fl3(), b3.if_rvalid, b3.dm_rvalid}, 0);
    check("t1_rst_bus3", {b3.mem_addr, b3.mem_size, b3.mem_sign, b3.dm_rdata}, 0);
    tick();
    b1.dm_req = 1'b0; b3.dm_req = 1'b0;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check("t1_if_gnt1", fl1(), 6'b100010);
    check("t1_addr1", b1.mem_addr, 32'h40);
    check("t1_szsg1", {b1.mem_size, b1.mem_sign}, 3'b100);
    check("t1_if_gnt3", fl3(), 6'b100010);
    check("t1_addr3", b3.mem_addr, 32'h44);
    tick();
    b1.if_req = 1'b0; b3.if_req = 1'b0;
    repeat (4) tick();

    // Starvation guard: four DM writes, then IF is forced through.
    b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 32'h300; b1.dm_wdata = 32'h1111_2222;
    b1.if_req = 1'b1; b1.if_addr = 32'h400;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check($sformatf("t3_dm_gnt%0d", k), fl1(), 6'b011011);
      check($sformatf("t3_wdata%0d", k), b1.mem_wdata, 32'h1111_2222 + k);
      tick();
      b1.dm_wdata = 32'h1111_2222 + k + 1;
    end
    @(negedge CLK);
    check("t3_if_forced", fl1(), 6'b100110);
    check("t3_if_addr", b1.mem_addr, 32'h400);
    tick();
    b1.if_req = 1'b0;
    @(negedge CLK);
    check("t3_wr_in_rv", {fl1(), b1.if_rvalid}, 7'b0100111);
`ifdef OTTER_ARB_PERF_EN
    check("t6_perf_if", perf1_if, 32'd4);
    check("t6_perf_dm", perf1_dm, 32'd1);
`endif
    tick();
    b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    repeat (2) tick();

    // Contention at MEM_LAT=1: DM read first, IF granted in DM's rvalid cycle.
    b1.if_req = 1'b1; b1.if_addr = 32'h200;
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 32'h100; b1.dm_size = 2'd0; b1.dm_sign = 1'b1;
    @(negedge CLK);
    check("t2_dm_gnt", fl1(), 6'b011010);
    check("t2_dm_cmd", {b1.mem_addr, b1.mem_size, b1.mem_sign}, {32'h100, 3'b001});
    tick();
    b1.dm_req = 1'b0;
    @(negedge CLK);
    check("t2_if_gnt", {fl1(), b1.dm_rvalid, b1.if_rvalid}, 8'b10001010);
    check("t2_if_cmd", {b1.mem_addr, b1.mem_size, b1.mem_sign}, {32'h200, 3'b100});
    tick();
    b1.if_req = 1'b0;
    @(negedge CLK);
    check("t2_if_rv", {fl1(), b1.if_rvalid, b1.dm_rvalid}, 8'b00000010);
    check("t2_dm_rdata0", b1.dm_rdata, 0);
    tick();
    repeat (2) tick();

    // MEM_LAT=3: rvalid three cycles after grant; DM held off until then.
    b3.if_req = 1'b1; b3.if_addr = 32'h0;
    @(negedge CLK);
    check("t4_if_gnt", fl3(), 6'b100010);
    tick();
    b3.if_req = 1'b0;
    b3.dm_req = 1'b1; b3.dm_we = 1'b0; b3.dm_addr = 32'h500; b3.dm_size = 2'd1; b3.dm_sign = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check($sformatf("t4_dm_wait%0d", k), {fl3(), b3.if_rvalid}, 7'b0001000);
      tick();
    end
    @(negedge CLK);
    check("t4_rv_gnt", {fl3(), b3.if_rvalid}, 7'b0100101);
    tick();
    b3.dm_req = 1'b0;
    repeat (2) tick();
    @(negedge CLK);
    check("t4_dm_rv", {b3.dm_rvalid, b3.if_rvalid}, 2'b10);
    repeat (2) tick();

    // Reset one cycle after a read grant: that read never returns.
    b1.if_req = 1'b1; b1.if_addr = 32'h600;
    b3.if_req = 1'b1; b3.if_addr = 32'h700;
    @(negedge CLK);
    check("t5_gnt1", fl1(), 6'b100010);
    check("t5_gnt3", fl3(), 6'b100010);
    tick();
    b1.if_req = 1'b0; b3.if_req = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("t5_rst_rv", {b1.if_rvalid, b3.if_rvalid}, 0);
    tick();
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check($sformatf("t5_no_rv%0d", k), {b1.if_rvalid, b1.dm_rvalid, b3.if_rvalid, b3.dm_rvalid}, 0);
      tick();
    end
    b1.if_req = 1'b1; b3.if_req = 1'b1;
    @(negedge CLK);
    check("t5_idle1", fl1(), 6'b100010);
    check("t5_idle3", fl3(), 6'b100010);
    tick();
    b1.if_req = 1'b0; b3.if_req = 1'b0;
    repeat (5) tick();

    @(negedge CLK);
    check("end_q1i", q1i.size(), 0);
    check("end_q1d", q1d.size(), 0);
    check("end_q3i", q3i.size(), 0);
    check("end_q3d", q3d.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
